// File: rtl/rij_fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// rij_fetch_ctrl_if
//   Bundles the signals between the multi-cycle control FSM and the R/I/J
//   datapath (IF stage, register file, ALU, data memory).
//
//   master modport : the control FSM (rij_fetch_ctrl)
//   slave  modport : the datapath / environment
//
//   Controller inputs : run, OP[5:0], func[5:0], ZF
//   Controller outputs: PC_Write, PC_s[1:0], IR_Write, Reg_Write, Mem_Write,
//                       ALU_OP[2:0], w_r_s[1:0], wr_data_s[1:0], rt_imm_s,
//                       imm_s, instr_done, illegal, state[2:0]
//   With PERF_CNT_EN defined: cyc_cnt[CNT_W-1:0], ret_cnt[CNT_W-1:0]
// ---------------------------------------------------------------------------
interface rij_fetch_ctrl_if #(
    parameter int CNT_W = 32
);
    logic       run;
    logic [5:0] OP;
    logic [5:0] func;
    logic       ZF;

    logic       PC_Write;
    logic [1:0] PC_s;
    logic       IR_Write;
    logic       Reg_Write;
    logic       Mem_Write;
    logic [2:0] ALU_OP;
    logic [1:0] w_r_s;
    logic [1:0] wr_data_s;
    logic       rt_imm_s;
    logic       imm_s;
    logic       instr_done;
    logic       illegal;
    logic [2:0] state;
`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] ret_cnt;
`endif

    modport master (
        input  run, OP, func, ZF,
        output PC_Write, PC_s, IR_Write, Reg_Write, Mem_Write, ALU_OP,
               w_r_s, wr_data_s, rt_imm_s, imm_s, instr_done, illegal, state
`ifdef PERF_CNT_EN
        , output cyc_cnt, ret_cnt
`endif
    );

    modport slave (
        output run, OP, func, ZF,
        input  PC_Write, PC_s, IR_Write, Reg_Write, Mem_Write, ALU_OP,
               w_r_s, wr_data_s, rt_imm_s, imm_s, instr_done, illegal, state
`ifdef PERF_CNT_EN
        , input cyc_cnt, ret_cnt
`endif
    );
endinterface

// File: rtl/rij_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// rij_fetch_ctrl
//   Multi-cycle control FSM for the R/I/J-type CPU. Sequences IF (PC, ROM,
//   IR), decodes OP/func held in the IR and drives the PC_next mux select,
//   register-file / data-memory enables and ALU controls for each state.
//
//   Ports:
//     clk    : system clock, FSM advances on posedge
//     rst_n  : asynchronous active-low reset (IDLE, all enables off)
//     bus    : rij_fetch_ctrl_if.master (run/OP/func/ZF in, controls out)
//
//   Optional feature macro: PERF_CNT_EN adds the cycle and retired-
//   instruction counters (cyc_cnt, ret_cnt) of width CNT_W.
//
//   Outputs are decoded from the current state plus OP/func/ZF so that the
//   branch enable can follow ZF within EX.
// ---------------------------------------------------------------------------
module rij_fetch_ctrl #(
    parameter int CNT_W = 32
) (
    input logic             clk,
    input logic             rst_n,
    rij_fetch_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5,
        S_TRAP = 3'd7
    } state_e;

    typedef enum logic [3:0] {
        K_RALU, K_JR, K_IALU, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_ILL
    } kind_e;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_NOR = 3'b011;
    localparam logic [2:0] ALU_ADD = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b110;
    localparam logic [2:0] ALU_SLL = 3'b111;

    state_e     state_q, state_d;
    kind_e      kind;
    logic [2:0] alu_op;
    logic       use_imm;
    logic       sext;
    logic       done;

    // Instruction decode from the IR fields.
    // NOTE: every signal written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        kind    = K_ILL;
        alu_op  = ALU_AND;
        use_imm = 1'b0;
        sext    = 1'b0;
        case (bus.OP)
            6'b000000: begin
                kind = K_RALU;
                case (bus.func)
                    6'b100100: alu_op = ALU_AND;
                    6'b100101: alu_op = ALU_OR;
                    6'b100110: alu_op = ALU_XOR;
                    6'b100111: alu_op = ALU_NOR;
                    6'b100000: alu_op = ALU_ADD;
                    6'b100010: alu_op = ALU_SUB;
                    6'b101011: alu_op = ALU_SLT;
                    6'b000100: alu_op = ALU_SLL;
                    6'b001000: kind   = K_JR;
                    default:   kind   = K_ILL;
                endcase
            end
            6'b001000: begin kind = K_IALU; alu_op = ALU_ADD; use_imm = 1'b1; sext = 1'b1; end
            6'b001100: begin kind = K_IALU; alu_op = ALU_AND; use_imm = 1'b1; end
            6'b001101: begin kind = K_IALU; alu_op = ALU_OR;  use_imm = 1'b1; end
            6'b001110: begin kind = K_IALU; alu_op = ALU_XOR; use_imm = 1'b1; end
            6'b001011: begin kind = K_IALU; alu_op = ALU_SLT; use_imm = 1'b1; sext = 1'b1; end
            6'b100011: begin kind = K_LW;   alu_op = ALU_ADD; use_imm = 1'b1; sext = 1'b1; end
            6'b101011: begin kind = K_SW;   alu_op = ALU_ADD; use_imm = 1'b1; sext = 1'b1; end
            6'b000100: begin kind = K_BEQ;  alu_op = ALU_SUB; end
            6'b000101: begin kind = K_BNE;  alu_op = ALU_SUB; end
            6'b000010: kind = K_J;
            6'b000011: kind = K_JAL;
            default:   kind = K_ILL;
        endcase
    end

    // Per-state control outputs and next state.
    always_comb begin
        state_d       = state_q;
        done          = 1'b0;
        bus.PC_Write  = 1'b0;
        bus.PC_s      = 2'b00;
        bus.IR_Write  = 1'b0;
        bus.Reg_Write = 1'b0;
        bus.Mem_Write = 1'b0;
        bus.ALU_OP    = 3'b000;
        bus.w_r_s     = 2'b00;
        bus.wr_data_s = 2'b00;
        bus.rt_imm_s  = 1'b0;
        bus.imm_s     = 1'b0;
        bus.illegal   = 1'b0;

        // ALU controls stay valid from EX through WB so the result and the
        // memory address remain stable while they are consumed.
        if (state_q == S_EX || state_q == S_MEM || state_q == S_WB) begin
            if (kind != K_JR) begin
                bus.ALU_OP   = alu_op;
                bus.rt_imm_s = use_imm;
                bus.imm_s    = sext;
            end
        end

        case (state_q)
            S_IDLE: if (bus.run) state_d = S_IF;
            S_IF: begin
                bus.IR_Write = 1'b1;
                bus.PC_Write = 1'b1;
                state_d      = S_ID;
            end
            S_ID: begin
                case (kind)
                    K_J, K_JAL: begin
                        bus.PC_Write = 1'b1;
                        bus.PC_s     = 2'b11;
                        done         = 1'b1;
                        if (kind == K_JAL) begin
                            bus.Reg_Write = 1'b1;
                            bus.w_r_s     = 2'b10;
                            bus.wr_data_s = 2'b10;
                        end
                    end
                    K_ILL:   state_d = S_TRAP;
                    default: state_d = S_EX;
                endcase
            end
            S_EX: begin
                case (kind)
                    K_JR: begin
                        bus.PC_Write = 1'b1;
                        bus.PC_s     = 2'b01;
                        done         = 1'b1;
                    end
                    K_BEQ, K_BNE: begin
                        bus.PC_s     = 2'b10;
                        bus.PC_Write = (kind == K_BEQ) ? bus.ZF : !bus.ZF;
                        done         = 1'b1;
                    end
                    K_LW, K_SW: state_d = S_MEM;
                    default:    state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (kind == K_SW) begin
                    bus.Mem_Write = 1'b1;
                    done          = 1'b1;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                bus.Reg_Write = 1'b1;
                if (kind == K_IALU || kind == K_LW) bus.w_r_s = 2'b01;
                if (kind == K_LW) bus.wr_data_s = 2'b01;
                done = 1'b1;
            end
            S_TRAP:  bus.illegal = 1'b1;
            default: state_d = S_IDLE;
        endcase

        // run is only consulted at an instruction boundary.
        if (done) state_d = bus.run ? S_IF : S_IDLE;
    end

    assign bus.instr_done = done;
    assign bus.state      = state_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] cyc_cnt_q, ret_cnt_q;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt_q <= '0;
            ret_cnt_q <= '0;
        end else begin
            if (state_q != S_IDLE && state_q != S_TRAP) cyc_cnt_q <= cyc_cnt_q + CNT_ONE;
            if (done) ret_cnt_q <= ret_cnt_q + CNT_ONE;
        end
    end

    assign bus.cyc_cnt = cyc_cnt_q;
    assign bus.ret_cnt = ret_cnt_q;
`endif

endmodule

// File: tb/tb_rij_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rij_fetch_ctrl
//   Self-checking bench for rij_fetch_ctrl: a vector table of instructions
//   with their expected latency / EX ALU op / branch outcome, hand-written
//   sequences for reset, trap and run-drop corners, and random instructions
//   checked cycle by cycle against an instruction-level reference model.
// ---------------------------------------------------------------------------
module tb_rij_fetch_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rij_fetch_ctrl_if #(.CNT_W(32)) bus ();
    rij_fetch_ctrl #(.CNT_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_s;
        logic       ir_write;
        logic       reg_write;
        logic       mem_write;
        logic [2:0] alu_op;
        logic [1:0] w_r_s;
        logic [1:0] wr_data_s;
        logic       rt_imm_s;
        logic       imm_s;
        logic       instr_done;
        logic       illegal;
        logic [2:0] state;
    } out_t;

    typedef enum {K_RALU, K_JR, K_IALU, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_ILL} kind_e;

    typedef struct {
        kind_e      kind;
        logic [2:0] alu;
        logic       rti;
        logic       sx;
    } ins_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       zf;
        int         lat;
        logic [2:0] alu;
        logic       chk_alu;
        logic       pcw;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic out_t sample();
        out_t o;
        o.pc_write   = bus.PC_Write;
        o.pc_s       = bus.PC_s;
        o.ir_write   = bus.IR_Write;
        o.reg_write  = bus.Reg_Write;
        o.mem_write  = bus.Mem_Write;
        o.alu_op     = bus.ALU_OP;
        o.w_r_s      = bus.w_r_s;
        o.wr_data_s  = bus.wr_data_s;
        o.rt_imm_s   = bus.rt_imm_s;
        o.imm_s      = bus.imm_s;
        o.instr_done = bus.instr_done;
        o.illegal    = bus.illegal;
        o.state      = bus.state;
        return o;
    endfunction

    // Instruction classification straight from the opcode / funct tables.
    function automatic ins_t decode(input logic [5:0] op, input logic [5:0] fn);
        ins_t d;
        d.kind = K_ILL; d.alu = 3'b000; d.rti = 1'b0; d.sx = 1'b0;
        case (op)
            6'h00: begin
                d.kind = K_RALU;
                case (fn)
                    6'h24: d.alu = 3'b000;
                    6'h25: d.alu = 3'b001;
                    6'h26: d.alu = 3'b010;
                    6'h27: d.alu = 3'b011;
                    6'h20: d.alu = 3'b100;
                    6'h22: d.alu = 3'b101;
                    6'h2B: d.alu = 3'b110;
                    6'h04: d.alu = 3'b111;
                    6'h08: d.kind = K_JR;
                    default: d.kind = K_ILL;
                endcase
            end
            6'h08: begin d.kind = K_IALU; d.alu = 3'b100; d.rti = 1; d.sx = 1; end
            6'h0C: begin d.kind = K_IALU; d.alu = 3'b000; d.rti = 1; end
            6'h0D: begin d.kind = K_IALU; d.alu = 3'b001; d.rti = 1; end
            6'h0E: begin d.kind = K_IALU; d.alu = 3'b010; d.rti = 1; end
            6'h0B: begin d.kind = K_IALU; d.alu = 3'b110; d.rti = 1; d.sx = 1; end
            6'h23: begin d.kind = K_LW;   d.alu = 3'b100; d.rti = 1; d.sx = 1; end
            6'h2B: begin d.kind = K_SW;   d.alu = 3'b100; d.rti = 1; d.sx = 1; end
            6'h04: begin d.kind = K_BEQ;  d.alu = 3'b101; end
            6'h05: begin d.kind = K_BNE;  d.alu = 3'b101; end
            6'h02: d.kind = K_J;
            6'h03: d.kind = K_JAL;
            default: d.kind = K_ILL;
        endcase
        return d;
    endfunction

    function automatic int latency(input kind_e k);
        case (k)
            K_J, K_JAL:         return 2;
            K_JR, K_BEQ, K_BNE: return 3;
            K_LW:               return 5;
            K_ILL:              return 0;
            default:            return 4;
        endcase
    endfunction

    // Expected outputs in cycle k (0 = fetch) of one instruction: the state
    // walks IF, ID, EX, then MEM for memory ops, then WB; the instruction's
    // effect and instr_done appear in its last cycle.
    function automatic out_t expect_cycle(input logic [5:0] op, input logic [5:0] fn,
                                          input logic zf, input int k);
        ins_t d = decode(op, fn);
        int   lat = latency(d.kind);
        out_t e = '0;
        if (k == 0) begin
            e.state = 3'd1; e.ir_write = 1'b1; e.pc_write = 1'b1;
            return e;
        end
        if (k == 1)      e.state = 3'd2;
        else if (k == 2) e.state = 3'd3;
        else if (k == 3) e.state = (d.kind == K_LW || d.kind == K_SW) ? 3'd4 : 3'd5;
        else             e.state = 3'd5;
        if (k >= 2 && d.kind != K_JR) begin
            e.alu_op = d.alu; e.rt_imm_s = d.rti; e.imm_s = d.sx;
        end
        if (k == lat - 1) begin
            e.instr_done = 1'b1;
            case (d.kind)
                K_J:   begin e.pc_write = 1; e.pc_s = 2'b11; end
                K_JAL: begin
                    e.pc_write = 1; e.pc_s = 2'b11; e.reg_write = 1;
                    e.w_r_s = 2'b10; e.wr_data_s = 2'b10;
                end
                K_JR:  begin e.pc_write = 1; e.pc_s = 2'b01; end
                K_BEQ: begin e.pc_write = zf;  e.pc_s = 2'b10; end
                K_BNE: begin e.pc_write = !zf; e.pc_s = 2'b10; end
                K_SW:  e.mem_write = 1;
                K_LW:  begin e.reg_write = 1; e.w_r_s = 2'b01; e.wr_data_s = 2'b01; end
                K_IALU: begin e.reg_write = 1; e.w_r_s = 2'b01; end
                default: e.reg_write = 1;
            endcase
        end
        return e;
    endfunction

    function automatic out_t idle_out();
        out_t e = '0;
        return e;
    endfunction

    function automatic out_t trap_out();
        out_t e = '0;
        e.illegal = 1'b1; e.state = 3'd7;
        return e;
    endfunction

    // Runs one instruction starting in IF; every cycle is checked against the
    // model. Bounded to 6 cycles; lat_seen = -1 if instr_done never rose.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic zf,
                             output int lat_seen, output logic [2:0] alu_ex,
                             output logic pcw_done);
        out_t o;
        lat_seen = -1; alu_ex = 3'b000; pcw_done = 1'b0;
        bus.OP = op; bus.func = fn; bus.ZF = zf;
        #1;
        for (int k = 0; k < 6; k++) begin
            o = sample();
            check($sformatf("op%02h_fn%02h_zf%0d_cyc%0d", op, fn, zf, k), o,
                  expect_cycle(op, fn, zf, k));
            if (k == 2) alu_ex = o.alu_op;
            if (o.instr_done) begin
                lat_seen = k + 1;
                pcw_done = o.pc_write;
                tick();
                break;
            end
            tick();
        end
    endtask

    vec_t vecs[22];
    int   lat;
    logic [2:0] alu;
    logic pcw;

    initial begin
        vecs[0]  = '{6'h00, 6'h20, 1'b0, 4, 3'b100, 1'b1, 1'b0};
        vecs[1]  = '{6'h00, 6'h22, 1'b0, 4, 3'b101, 1'b1, 1'b0};
        vecs[2]  = '{6'h00, 6'h24, 1'b0, 4, 3'b000, 1'b1, 1'b0};
        vecs[3]  = '{6'h00, 6'h25, 1'b0, 4, 3'b001, 1'b1, 1'b0};
        vecs[4]  = '{6'h00, 6'h26, 1'b0, 4, 3'b010, 1'b1, 1'b0};
        vecs[5]  = '{6'h00, 6'h27, 1'b0, 4, 3'b011, 1'b1, 1'b0};
        vecs[6]  = '{6'h00, 6'h2B, 1'b0, 4, 3'b110, 1'b1, 1'b0};
        vecs[7]  = '{6'h00, 6'h04, 1'b0, 4, 3'b111, 1'b1, 1'b0};
        vecs[8]  = '{6'h00, 6'h08, 1'b0, 3, 3'b000, 1'b0, 1'b1};
        vecs[9]  = '{6'h08, 6'h00, 1'b0, 4, 3'b100, 1'b1, 1'b0};
        vecs[10] = '{6'h0C, 6'h00, 1'b0, 4, 3'b000, 1'b1, 1'b0};
        vecs[11] = '{6'h0D, 6'h00, 1'b0, 4, 3'b001, 1'b1, 1'b0};
        vecs[12] = '{6'h0E, 6'h00, 1'b0, 4, 3'b010, 1'b1, 1'b0};
        vecs[13] = '{6'h0B, 6'h00, 1'b0, 4, 3'b110, 1'b1, 1'b0};
        vecs[14] = '{6'h23, 6'h00, 1'b0, 5, 3'b100, 1'b1, 1'b0};
        vecs[15] = '{6'h2B, 6'h00, 1'b0, 4, 3'b100, 1'b1, 1'b0};
        vecs[16] = '{6'h04, 6'h00, 1'b1, 3, 3'b101, 1'b1, 1'b1};
        vecs[17] = '{6'h04, 6'h00, 1'b0, 3, 3'b101, 1'b1, 1'b0};
        vecs[18] = '{6'h05, 6'h00, 1'b0, 3, 3'b101, 1'b1, 1'b1};
        vecs[19] = '{6'h05, 6'h00, 1'b1, 3, 3'b101, 1'b1, 1'b0};
        vecs[20] = '{6'h02, 6'h00, 1'b0, 2, 3'b000, 1'b0, 1'b1};
        vecs[21] = '{6'h03, 6'h00, 1'b0, 2, 3'b000, 1'b0, 1'b1};

        bus.run = 1'b0; bus.OP = 6'h00; bus.func = 6'h00; bus.ZF = 1'b0;
        #1;
        check("reset_outputs", sample(), idle_out());
        tick();
        rst_n = 1'b1;

        // Idle with run low for 5 cycles.
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("idle_run0_%0d", i), sample(), idle_out());
        end
`ifdef PERF_CNT_EN
        check("idle_cyc_cnt", bus.cyc_cnt, 32'd0);
        check("idle_ret_cnt", bus.ret_cnt, 32'd0);
`endif
        bus.run = 1'b1;
        tick();

        // Vector table, run held high so instructions issue back to back.
        foreach (vecs[i]) begin
            run_instr(vecs[i].op, vecs[i].fn, vecs[i].zf, lat, alu, pcw);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_pc_write_done", i), pcw, vecs[i].pcw);
            if (vecs[i].chk_alu) check($sformatf("vec%0d_alu_ex", i), alu, vecs[i].alu);
        end

        // jal, then an undecodable opcode traps; run toggling is ignored.
        run_instr(6'h03, 6'h00, 1'b0, lat, alu, pcw);
        check("jal_latency", lat, 2);
        bus.OP = 6'h3F; bus.func = 6'h00;
        #1;
        check("ill_if", sample(), expect_cycle(6'h3F, 6'h00, 1'b0, 0));
        tick();
        check("ill_id", sample(), expect_cycle(6'h3F, 6'h00, 1'b0, 1));
        for (int i = 0; i < 6; i++) begin
            tick();
            bus.run = i[0];
            bus.OP  = 6'h00;
            #1;
            check($sformatf("trap_hold_%0d", i), sample(), trap_out());
        end
        rst_n = 1'b0;
        #1;
        check("trap_reset", sample(), idle_out());
        bus.run = 1'b0;
        tick();
        rst_n = 1'b1;

        // Drop run during EX: the add completes, then IDLE.
        bus.run = 1'b1;
        tick();
        bus.OP = 6'h00; bus.func = 6'h20; bus.ZF = 1'b0;
        #1;
        check("drop_if", sample(), expect_cycle(6'h00, 6'h20, 1'b0, 0));
        tick();
        tick();
        bus.run = 1'b0;
        #1;
        check("drop_ex", sample(), expect_cycle(6'h00, 6'h20, 1'b0, 2));
        tick();
        check("drop_wb", sample(), expect_cycle(6'h00, 6'h20, 1'b0, 3));
        tick();
        check("drop_idle", sample(), idle_out());
        tick();
        check("drop_idle_stays", sample(), idle_out());

        // Asynchronous reset while in EX.
        bus.run = 1'b1;
        tick();
        tick();
        tick();
        check("rst_ex_state", bus.state, 3'd3);
        rst_n = 1'b0;
        #1;
        check("rst_ex_outputs", sample(), idle_out());
`ifdef PERF_CNT_EN
        check("rst_ex_cyc_cnt", bus.cyc_cnt, 32'd0);
        check("rst_ex_ret_cnt", bus.ret_cnt, 32'd0);
`endif
        tick();
        rst_n = 1'b1;
        tick();
        run_instr(6'h00, 6'h20, 1'b0, lat, alu, pcw);
        check("post_rst_add_latency", lat, 4);
`ifdef PERF_CNT_EN
        check("perf_ret_cnt", bus.ret_cnt, 32'd1);
        check("perf_cyc_cnt", bus.cyc_cnt, 32'd4);
`endif

        // Random legal instructions with random ZF.
        for (int n = 0; n < 200; n++) begin
            int idx;
            logic zf;
            idx = int'($urandom_range(0, 21));
            zf  = 1'($urandom);
            run_instr(vecs[idx].op, vecs[idx].fn, zf, lat, alu, pcw);
            check($sformatf("rand%0d_latency", n), lat,
                  latency(decode(vecs[idx].op, vecs[idx].fn).kind));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
